// File: rtl/alarm_set_ctrl.sv
// Alarm clock setting controller: mode/increment key FSM that edits the clock and
// alarm times through shadow registers, plus alarm match detection and bell timing.
`timescale 1ns/1ps

module alarm_set_ctrl #(
  parameter logic [7:0] RING_SEC = 8'd60
) (
  input  logic       CP,
  input  logic       nCR,
  input  logic       TICK_1,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  input  logic       KEY_STOP,
  input  logic [7:0] TIME_H,
  input  logic [7:0] TIME_M,
  input  logic [7:0] TIME_S,
  output logic [7:0] D_H,
  output logic [7:0] D_M,
  output logic [7:0] D_S,
  output logic       PE_CLK,
  output logic [7:0] ALM_H,
  output logic [7:0] ALM_M,
  output logic [2:0] MODE,
  output logic       ALM_EN,
  output logic       RING
);

  typedef enum logic [2:0] {
    StRun   = 3'd0,
    StClkH  = 3'd1,
    StClkM  = 3'd2,
    StAlmSh = 3'd3,
    StAlmSm = 3'd4
  } state_e;

  state_e     state_q;
  logic [7:0] sh_q, sm_q, alm_h_q, alm_m_q, pe_h_q, pe_m_q, ring_cnt_q;
  logic       pe_clk_q, alm_en_q, ring_q;
  logic [2:0] key_q, key_qq;
  logic       mode_ev, inc_ev, stop_ev, trigger;

  // BCD hour increment, 00..23 with wrap.
  function automatic logic [7:0] inc_hour(input logic [7:0] h);
    if (h >= 8'h23)          return 8'h00;
    else if (h[3:0] >= 4'd9) return {h[7:4] + 4'd1, 4'd0};
    else                     return h + 8'd1;
  endfunction

  // BCD minute increment, 00..59 with wrap.
  function automatic logic [7:0] inc_min(input logic [7:0] m);
    if (m >= 8'h59)          return 8'h00;
    else if (m[3:0] >= 4'd9) return {m[7:4] + 4'd1, 4'd0};
    else                     return m + 8'd1;
  endfunction

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      key_q  <= 3'b000;
      key_qq <= 3'b000;
    end else begin
      key_q  <= {KEY_STOP, KEY_INC, KEY_MODE};
      key_qq <= key_q;
    end
  end

  assign mode_ev = key_q[0] & ~key_qq[0];
  assign inc_ev  = key_q[1] & ~key_qq[1];
  assign stop_ev = key_q[2] & ~key_qq[2];

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q  <= StRun;
      sh_q     <= 8'h00;
      sm_q     <= 8'h00;
      alm_h_q  <= 8'h00;
      alm_m_q  <= 8'h00;
      pe_h_q   <= 8'h00;
      pe_m_q   <= 8'h00;
      pe_clk_q <= 1'b0;
    end else begin
      pe_clk_q <= 1'b0;
      // MODE has priority; a coincident INC is dropped.
      case (state_q)
        StRun: begin
          if (mode_ev) begin
            state_q <= StClkH;
            sh_q    <= TIME_H;
            sm_q    <= TIME_M;
          end
        end
        StClkH: begin
          if (mode_ev)     state_q <= StClkM;
          else if (inc_ev) sh_q    <= inc_hour(sh_q);
        end
        StClkM: begin
          if (mode_ev) begin
            state_q  <= StAlmSh;
            pe_clk_q <= 1'b1;
            pe_h_q   <= sh_q;
            pe_m_q   <= sm_q;
            sh_q     <= alm_h_q;
            sm_q     <= alm_m_q;
          end else if (inc_ev) begin
            sm_q <= inc_min(sm_q);
          end
        end
        StAlmSh: begin
          if (mode_ev)     state_q <= StAlmSm;
          else if (inc_ev) sh_q    <= inc_hour(sh_q);
        end
        StAlmSm: begin
          if (mode_ev) begin
            state_q <= StRun;
            alm_h_q <= sh_q;
            alm_m_q <= sm_q;
          end else if (inc_ev) begin
            sm_q <= inc_min(sm_q);
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign trigger = TICK_1 & alm_en_q & ~ring_q & (TIME_H == alm_h_q) & (TIME_M == alm_m_q) &
                   (TIME_S == 8'h00);

  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      alm_en_q   <= 1'b0;
      ring_q     <= 1'b0;
      ring_cnt_q <= 8'd0;
    end else if (stop_ev) begin
      // STOP silences the bell if ringing, otherwise arms/disarms; it beats a trigger.
      if (ring_q) begin
        ring_q     <= 1'b0;
        ring_cnt_q <= 8'd0;
      end else begin
        alm_en_q <= ~alm_en_q;
      end
    end else if (ring_q) begin
      if (TICK_1) begin
        if (ring_cnt_q <= 8'd1) begin
          ring_q     <= 1'b0;
          ring_cnt_q <= 8'd0;
        end else begin
          ring_cnt_q <= ring_cnt_q - 8'd1;
        end
      end
    end else if (trigger) begin
      ring_q     <= 1'b1;
      ring_cnt_q <= RING_SEC;
    end
  end

  assign PE_CLK = pe_clk_q;
  assign D_H    = pe_clk_q ? pe_h_q : sh_q;
  assign D_M    = pe_clk_q ? pe_m_q : sm_q;
  assign D_S    = 8'h00;
  assign ALM_H  = alm_h_q;
  assign ALM_M  = alm_m_q;
  assign MODE   = state_q;
  assign ALM_EN = alm_en_q;
  assign RING   = ring_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Bench for alarm_set_ctrl: directed scenarios followed by random key/tick traffic,
// checked against an integer-valued model of the setting and alarm rules.
`timescale 1ns/1ps

module tb_alarm_set_ctrl;

  localparam int RS = 60;

  logic       CP = 1'b0, nCR = 1'b0, TICK_1 = 1'b0;
  logic       KEY_MODE = 1'b0, KEY_INC = 1'b0, KEY_STOP = 1'b0;
  logic [7:0] TIME_H = 8'h00, TIME_M = 8'h00, TIME_S = 8'h00;
  logic [7:0] D_H, D_M, D_S, ALM_H, ALM_M;
  logic       PE_CLK, ALM_EN, RING;
  logic [2:0] MODE;

  alarm_set_ctrl #(.RING_SEC(8'd60)) dut (
    .CP(CP), .nCR(nCR), .TICK_1(TICK_1), .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC),
    .KEY_STOP(KEY_STOP), .TIME_H(TIME_H), .TIME_M(TIME_M), .TIME_S(TIME_S), .D_H(D_H),
    .D_M(D_M), .D_S(D_S), .PE_CLK(PE_CLK), .ALM_H(ALM_H), .ALM_M(ALM_M), .MODE(MODE),
    .ALM_EN(ALM_EN), .RING(RING)
  );

  always #5 CP = ~CP;

  int n_chk = 0, n_fail = 0;
  // Model: state 0..4, fields as plain integers, time as integers.
  int m_st = 0, m_sh = 0, m_sm = 0, m_ah = 0, m_am = 0, m_en = 0, m_ring = 0, m_cnt = 0;
  int th = 0, tm = 0, ts = 0;
  int exp_pe = 0, exp_pe_h = 0, exp_pe_m = 0;
  int pe_cnt = 0;
  logic [7:0] pe_dh = 8'h00, pe_dm = 8'h00, pe_ds = 8'h00;

  always @(negedge CP) begin
    if (PE_CLK === 1'b1) begin
      pe_cnt = pe_cnt + 1;
      pe_dh  = D_H;
      pe_dm  = D_M;
      pe_ds  = D_S;
    end
  end

  function automatic logic [7:0] bcd(input int n);
    return 8'((n / 10) * 16 + (n % 10));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CP);
    #1;
  endtask

  task automatic drive_time();
    TIME_H = bcd(th);
    TIME_M = bcd(tm);
    TIME_S = bcd(ts);
  endtask

  task automatic model_mode();
    case (m_st)
      0: begin m_sh = th; m_sm = tm; m_st = 1; end
      1: m_st = 2;
      2: begin
        exp_pe++; exp_pe_h = m_sh; exp_pe_m = m_sm;
        m_sh = m_ah; m_sm = m_am; m_st = 3;
      end
      3: m_st = 4;
      default: begin m_ah = m_sh; m_am = m_sm; m_st = 0; end
    endcase
  endtask

  task automatic model_inc();
    if (m_st == 1 || m_st == 3) m_sh = (m_sh + 1) % 24;
    else if (m_st == 2 || m_st == 4) m_sm = (m_sm + 1) % 60;
  endtask

  task automatic press(input bit m, input bit i, input bit s);
    KEY_MODE = m; KEY_INC = i; KEY_STOP = s;
    repeat (3) step();
    KEY_MODE = 1'b0; KEY_INC = 1'b0; KEY_STOP = 1'b0;
    repeat (3) step();
    if (s) begin
      if (m_ring != 0) begin m_ring = 0; m_cnt = 0; end
      else m_en = 1 - m_en;
    end
    if (m) model_mode();
    else if (i) model_inc();
  endtask

  task automatic tick();
    drive_time();
    TICK_1 = 1'b1;
    step();
    TICK_1 = 1'b0;
    if (m_ring != 0) begin
      m_cnt--;
      if (m_cnt == 0) m_ring = 0;
    end else if (m_en != 0 && th == m_ah && tm == m_am && ts == 0) begin
      m_ring = 1; m_cnt = RS;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "/mode"}, 32'(MODE), 32'(m_st));
    check({tag, "/d_h"}, 32'(D_H), 32'(bcd(m_sh)));
    check({tag, "/d_m"}, 32'(D_M), 32'(bcd(m_sm)));
    check({tag, "/d_s"}, 32'(D_S), 32'h0);
    check({tag, "/alm_h"}, 32'(ALM_H), 32'(bcd(m_ah)));
    check({tag, "/alm_m"}, 32'(ALM_M), 32'(bcd(m_am)));
    check({tag, "/alm_en"}, 32'(ALM_EN), 32'(m_en));
    check({tag, "/ring"}, 32'(RING), 32'(m_ring));
    check({tag, "/pe_clk"}, 32'(PE_CLK), 32'h0);
    check({tag, "/pe_cnt"}, 32'(pe_cnt), 32'(exp_pe));
  endtask

  task automatic set_alarm(input int h, input int m);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    repeat ((h - m_sh + 24) % 24) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    repeat ((m - m_sm + 60) % 60) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int op;
    repeat (2) step();
    check_all("reset");
    nCR = 1'b1;
    repeat (2) step();

    // Set clock from 10:15.
    th = 10; tm = 15; ts = 5; drive_time();
    press(1'b1, 1'b0, 1'b0);
    repeat (3) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    repeat (46) press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    check("setclk/pe_cnt", 32'(pe_cnt), 32'd1);
    check("setclk/pe_dh", 32'(pe_dh), 32'h13);
    check("setclk/pe_dm", 32'(pe_dm), 32'h01);
    check("setclk/pe_ds", 32'(pe_ds), 32'h00);
    check("setclk/mode", 32'(MODE), 32'd3);
    check_all("setclk");
    repeat (2) press(1'b1, 1'b0, 1'b0);
    check_all("setclk_run");

    // Hour and minute wrap.
    th = 23; tm = 59; drive_time();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("wrap/h", 32'(D_H), 32'h00);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    check("wrap/m", 32'(D_M), 32'h00);
    check_all("wrap");
    repeat (3) press(1'b1, 1'b0, 1'b0);

    // MODE and INC together in CLK_H.
    th = 4; tm = 44; drive_time();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    press(1'b1, 1'b1, 1'b0);
    check("collide/mode", 32'(MODE), 32'd2);
    check("collide/sh", 32'(D_H), 32'h05);
    check_all("collide");
    repeat (3) press(1'b1, 1'b0, 1'b0);

    // Alarm at 07:30, armed; current time equal on leaving ALM_SM must not ring.
    th = 7; tm = 30; ts = 0; drive_time();
    set_alarm(7, 30);
    check("alarm/alm_h", 32'(ALM_H), 32'h07);
    check("alarm/alm_m", 32'(ALM_M), 32'h30);
    if (m_en == 0) press(1'b0, 1'b0, 1'b1);
    check_all("armed");
    tick();
    check("ring/on", 32'(RING), 32'd1);
    ts = 1;
    repeat (RS - 1) tick();
    check("ring/held", 32'(RING), 32'd1);
    tick();
    check("ring/off", 32'(RING), 32'd0);
    check_all("ring");

    // STOP after 5 ticks, then next day's match.
    ts = 0; tick();
    ts = 1; repeat (5) tick();
    check("stop/ringing", 32'(RING), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check("stop/ring", 32'(RING), 32'd0);
    check("stop/en", 32'(ALM_EN), 32'd1);
    check_all("stop");
    ts = 0; tick();
    check("nextday/ring", 32'(RING), 32'd1);
    press(1'b0, 1'b0, 1'b1);
    check_all("nextday");

    // STOP edge coinciding with a matching tick: STOP wins, alarm disarms.
    ts = 0; drive_time();
    KEY_STOP = 1'b1;
    step();
    TICK_1 = 1'b1;
    step();
    TICK_1 = 1'b0;
    m_en = 0;
    check("stop_trig/ring", 32'(RING), 32'd0);
    check("stop_trig/en", 32'(ALM_EN), 32'd0);
    step();
    KEY_STOP = 1'b0;
    repeat (3) step();
    check_all("stop_trig");

    // Random traffic.
    for (int k = 0; k < 80; k++) begin
      op = int'($urandom_range(0, 6));
      case (op)
        0:       press(1'b1, 1'b0, 1'b0);
        1, 2:    press(1'b0, 1'b1, 1'b0);
        3:       press(1'b0, 1'b0, 1'b1);
        4:       press(1'b1, 1'b1, 1'b0);
        default: begin
          if ($urandom_range(0, 1) == 1) begin
            th = m_ah; tm = m_am; ts = 0;
          end else begin
            th = int'($urandom_range(0, 23));
            tm = int'($urandom_range(0, 59));
            ts = int'($urandom_range(0, 59));
          end
          tick();
        end
      endcase
      check_all("rand");
      if (m_st == 2 && exp_pe > 0) begin
        check("rand/pe_dh", 32'(pe_dh), 32'(bcd(exp_pe_h)));
      end
    end
    if (exp_pe > 0) begin
      check("rand/pe_dh_last", 32'(pe_dh), 32'(bcd(exp_pe_h)));
      check("rand/pe_dm_last", 32'(pe_dm), 32'(bcd(exp_pe_m)));
    end

    // Reset mid-setting in ALM_SM with an edited shadow value.
    th = 9; tm = 9; ts = 9; drive_time();
    if (m_ah == 0 && m_am == 0) set_alarm(3, 33);
    while (m_st != 4) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b1, 1'b0);
    #2;
    nCR = 1'b0;
    #1;
    m_st = 0; m_sh = 0; m_sm = 0; m_ah = 0; m_am = 0; m_en = 0; m_ring = 0; m_cnt = 0;
    check_all("rst_async");
    repeat (3) step();
    check_all("rst_hold");
    nCR = 1'b1;
    repeat (3) step();
    check_all("rst_release");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
